// File: rtl/clock_sched.sv
// Round-robin scheduler that programs a shared oscillator controller for four requesters.
// Define CLOCK_SCHED_RETRY_EN to retry a failed lock attempt twice before reporting failure.
module clock_sched #(
  parameter int unsigned RST_CYCLES = 8,
  parameter logic [15:0] TIMEOUT    = 16'hFFFF,
  parameter logic [15:0] REF_WINDOW = 16'd1000
) (
  input  logic        ref_clk,
  input  logic        resetn,
  input  logic [3:0]  req_valid,
  input  logic [35:0] req_init,
  input  logic [63:0] req_counter,
  output logic [3:0]  req_ack,
  output logic        req_ok,
  output logic [1:0]  owner,
  output logic        busy,
  output logic        lock_lost,
  output logic        osc_resetn,
  output logic [8:0]  osc_init,
  output logic [15:0] osc_counter,
  output logic [15:0] osc_ref_counter,
  input  logic [2:0]  osc_status
);

  localparam logic [15:0] RstLast = 16'(RST_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StRst, StWait, StHold} state_e;

  state_e      state;
  logic [2:0]  sync1;
  logic [2:0]  st;
  logic [15:0] rst_cnt;
  logic [15:0] tmo;
  logic [15:0] tmo_inc;
  logic [1:0]  winner;
  logic        req_any;
  logic [8:0]  win_init;
  logic [15:0] win_counter;
`ifdef CLOCK_SCHED_RETRY_EN
  logic [1:0]  retry;
`endif

  assign osc_ref_counter = REF_WINDOW;
  assign req_any         = |req_valid;
  assign tmo_inc         = (tmo == 16'hFFFF) ? tmo : tmo + 16'd1;

  // Search starts just after the last owner; k=4 wraps back to the owner itself.
  always_comb begin
    winner = owner;
    for (int k = 4; k >= 1; k--) begin
      if (req_valid[owner + 2'(k)]) winner = owner + 2'(k);
    end
    win_init    = req_init[9*int'(winner) +: 9];
    win_counter = req_counter[16*int'(winner) +: 16];
  end

  always_ff @(posedge ref_clk or negedge resetn) begin
    if (!resetn) begin
      sync1 <= '0;
      st    <= '0;
    end else begin
      sync1 <= osc_status;
      st    <= sync1;
    end
  end

  always_ff @(posedge ref_clk or negedge resetn) begin
    if (!resetn) begin
      state       <= StIdle;
      osc_resetn  <= 1'b0;
      osc_init    <= '0;
      osc_counter <= '0;
      owner       <= 2'd3;
      req_ack     <= '0;
      req_ok      <= 1'b0;
      busy        <= 1'b0;
      lock_lost   <= 1'b0;
      rst_cnt     <= '0;
      tmo         <= '0;
`ifdef CLOCK_SCHED_RETRY_EN
      retry       <= '0;
`endif
    end else begin
      req_ack <= '0;
      req_ok  <= 1'b0;
      case (state)
        StIdle, StHold: begin
          if (req_any) begin
            owner       <= winner;
            osc_init    <= win_init;
            osc_counter <= win_counter;
            osc_resetn  <= 1'b0;
            busy        <= 1'b1;
            lock_lost   <= 1'b0;
            rst_cnt     <= '0;
            state       <= StRst;
`ifdef CLOCK_SCHED_RETRY_EN
            retry       <= '0;
`endif
          end else if (state == StHold && !st[0]) begin
            lock_lost <= 1'b1;
          end
        end
        StRst: begin
          if (rst_cnt >= RstLast) begin
            osc_resetn <= 1'b1;
            tmo        <= '0;
            state      <= StWait;
          end else begin
            rst_cnt <= rst_cnt + 16'd1;
          end
        end
        StWait: begin
          if (st[0]) begin
            req_ack <= 4'b0001 << owner;
            req_ok  <= 1'b1;
            busy    <= 1'b0;
            state   <= StHold;
          end else if (st[2] || tmo_inc >= TIMEOUT) begin
`ifdef CLOCK_SCHED_RETRY_EN
            if (retry < 2'd2) begin
              retry      <= retry + 2'd1;
              rst_cnt    <= '0;
              osc_resetn <= 1'b0;
              state      <= StRst;
            end else
`endif
            begin
              req_ack    <= 4'b0001 << owner;
              req_ok     <= 1'b0;
              busy       <= 1'b0;
              osc_resetn <= 1'b0;
              state      <= StIdle;
            end
          end else begin
            tmo <= tmo_inc;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_clock_sched.sv
// Scoreboard bench for clock_sched: stimulus pushes expected acks, a monitor pops on each ack.
module tb_clock_sched;

  logic        ref_clk = 1'b0;
  logic        resetn;
  logic [3:0]  req_valid;
  logic [35:0] req_init;
  logic [63:0] req_counter;
  logic [3:0]  req_ack;
  logic        req_ok;
  logic [1:0]  owner;
  logic        busy;
  logic        lock_lost;
  logic        osc_resetn;
  logic [8:0]  osc_init;
  logic [15:0] osc_counter;
  logic [15:0] osc_ref_counter;
  logic [2:0]  osc_status;

  typedef struct packed {
    logic [3:0]  ack;
    logic        ok;
    logic [1:0]  own;
    logic [8:0]  init;
    logic [15:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad = 0;
  int   ack_count = 0;
  int   rst_phases = 0;
  logic prev_rst = 1'b0;

  clock_sched #(.TIMEOUT(16'd100)) dut (
    .ref_clk         (ref_clk),
    .resetn          (resetn),
    .req_valid       (req_valid),
    .req_init        (req_init),
    .req_counter     (req_counter),
    .req_ack         (req_ack),
    .req_ok          (req_ok),
    .owner           (owner),
    .busy            (busy),
    .lock_lost       (lock_lost),
    .osc_resetn      (osc_resetn),
    .osc_init        (osc_init),
    .osc_counter     (osc_counter),
    .osc_ref_counter (osc_ref_counter),
    .osc_status      (osc_status)
  );

  always #5 ref_clk = ~ref_clk;

  function automatic logic [8:0] init_of(input int i);
    return 9'(100 + 11 * i);
  endfunction

  function automatic logic [15:0] cnt_of(input int i);
    return 16'(5000 + 123 * i);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic void push(input int idx, input logic ok);
    exp_t e;
    e.ack  = 4'(1 << idx);
    e.ok   = ok;
    e.own  = 2'(idx);
    e.init = init_of(idx);
    e.cnt  = cnt_of(idx);
    exp_q.push_back(e);
  endfunction

  // Monitor: every ack must match the oldest expectation.
  always @(negedge ref_clk) begin
    if (resetn === 1'b1 && req_ack !== 4'b0000) begin
      ack_count++;
      if (exp_q.size() == 0) begin
        chk("unexpected_ack", 32'(req_ack), 32'h0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("ack_bits", 32'(req_ack), 32'(e.ack));
        chk("ack_ok", 32'(req_ok), 32'(e.ok));
        chk("ack_owner", 32'(owner), 32'(e.own));
        chk("ack_init", 32'(osc_init), 32'(e.init));
        chk("ack_counter", 32'(osc_counter), 32'(e.cnt));
      end
    end
  end

  // Counts entries into the oscillator-reset phase of a granted attempt.
  always @(negedge ref_clk) begin
    if ((busy && !osc_resetn) && !prev_rst) rst_phases++;
    prev_rst = busy && !osc_resetn;
  end

  task automatic do_reset();
    @(negedge ref_clk);
    resetn     = 1'b0;
    req_valid  = 4'b0000;
    osc_status = 3'b000;
    repeat (3) @(negedge ref_clk);
    resetn = 1'b1;
    @(negedge ref_clk);
  endtask

  task automatic wait_acks(input int target, input int budget, input string name);
    int n = 0;
    while (ack_count < target && n < budget) begin
      @(negedge ref_clk);
      #1;
      n++;
    end
    chk(name, 32'(ack_count), 32'(target));
  endtask

  task automatic wait_wait_entry(input string name);
    int n = 0;
    while (!(osc_resetn && busy) && n < 40) begin
      @(negedge ref_clk);
      n++;
    end
    chk(name, 32'(osc_resetn && busy), 32'h1);
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_osc_resetn"}, 32'(osc_resetn), 32'h0);
    chk({tag, "_osc_init"}, 32'(osc_init), 32'h0);
    chk({tag, "_osc_counter"}, 32'(osc_counter), 32'h0);
    chk({tag, "_owner"}, 32'(owner), 32'h3);
    chk({tag, "_req_ack"}, 32'(req_ack), 32'h0);
    chk({tag, "_req_ok"}, 32'(req_ok), 32'h0);
    chk({tag, "_busy"}, 32'(busy), 32'h0);
    chk({tag, "_lock_lost"}, 32'(lock_lost), 32'h0);
    chk({tag, "_ref_counter"}, 32'(osc_ref_counter), 32'd1000);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int low;
    int base;
    int ph;
    int n;
    resetn     = 1'b0;
    req_valid  = 4'b0000;
    osc_status = 3'b000;
    for (int i = 0; i < 4; i++) begin
      req_init[9*i +: 9]     = init_of(i);
      req_counter[16*i +: 16] = cnt_of(i);
    end
    #12;
    check_reset_values("reset");

    // Single request that locks 20 cycles after the grant.
    do_reset();
    req_valid = 4'b0001;
    @(negedge ref_clk);
    chk("t1_owner", 32'(owner), 32'h0);
    chk("t1_init", 32'(osc_init), 32'd100);
    chk("t1_counter", 32'(osc_counter), 32'd5000);
    chk("t1_busy", 32'(busy), 32'h1);
    req_valid = 4'b0000;
    low = 1;
    for (int i = 0; i < 40; i++) begin
      @(negedge ref_clk);
      if (busy && !osc_resetn) low++;
      else break;
    end
    chk("t1_rst_low_cycles", 32'(low), 32'd8);
    base = ack_count;
    repeat (11) @(negedge ref_clk);
    osc_status = 3'b001;
    push(0, 1'b1);
    wait_acks(base + 1, 20, "t1_ack_seen");
    @(negedge ref_clk);
    chk("t1_hold_resetn", 32'(osc_resetn), 32'h1);
    chk("t1_hold_busy", 32'(busy), 32'h0);

    // All four requesting continuously: order 0,1,2,3,0.
    do_reset();
    osc_status = 3'b001;
    base = ack_count;
    push(0, 1'b1);
    push(1, 1'b1);
    push(2, 1'b1);
    push(3, 1'b1);
    push(0, 1'b1);
    req_valid = 4'b1111;
    wait_acks(base + 5, 200, "t2_five_acks");
    req_valid = 4'b0000;
    @(negedge ref_clk);
    chk("t2_final_owner", 32'(owner), 32'h0);
    chk("t2_idle_busy", 32'(busy), 32'h0);

    // Calibration failure pulsed during WAIT.
    do_reset();
    base = ack_count;
    ph   = rst_phases;
    req_valid = 4'b0001;
    @(negedge ref_clk);
    req_valid = 4'b0000;
    wait_wait_entry("t3_wait_entry");
    osc_status = 3'b100;
    push(0, 1'b0);
    @(negedge ref_clk);
    osc_status = 3'b000;
    wait_acks(base + 1, 500, "t3_ack_seen");
`ifdef CLOCK_SCHED_RETRY_EN
    chk("t3_rst_phases", 32'(rst_phases - ph), 32'd3);
`else
    chk("t3_rst_phases", 32'(rst_phases - ph), 32'd1);
`endif
    chk("t3_osc_resetn", 32'(osc_resetn), 32'h0);
    chk("t3_busy", 32'(busy), 32'h0);

    // Timeout with status held low.
    do_reset();
    push(0, 1'b0);
    req_valid = 4'b0001;
    @(negedge ref_clk);
    req_valid = 4'b0000;
    wait_wait_entry("t4_wait_entry");
    n = 0;
    while (n < 400 && req_ack == 4'b0000) begin
      @(negedge ref_clk);
      n++;
    end
`ifdef CLOCK_SCHED_RETRY_EN
    chk("t4_timeout_cycles", 32'(n), 32'd316);
`else
    chk("t4_timeout_cycles", 32'(n), 32'd100);
`endif

    // Lock lost in HOLD stays set until the next grant.
    do_reset();
    osc_status = 3'b001;
    base = ack_count;
    push(0, 1'b1);
    req_valid = 4'b0001;
    @(negedge ref_clk);
    req_valid = 4'b0000;
    wait_acks(base + 1, 40, "t5_lock_ack");
    osc_status = 3'b000;
    repeat (5) @(negedge ref_clk);
    chk("t5_lock_lost_set", 32'(lock_lost), 32'h1);
    repeat (5) @(negedge ref_clk);
    chk("t5_lock_lost_held", 32'(lock_lost), 32'h1);
    chk("t5_still_hold", 32'(osc_resetn), 32'h1);
    req_valid = 4'b0100;
    push(2, 1'b0);
    @(negedge ref_clk);
    req_valid = 4'b0000;
    chk("t5_owner2", 32'(owner), 32'h2);
    chk("t5_lock_lost_clr", 32'(lock_lost), 32'h0);
    chk("t5_init2", 32'(osc_init), 32'(init_of(2)));
    wait_acks(base + 2, 500, "t5_fail_ack");

    // Reset in the middle of WAIT aborts silently.
    do_reset();
    base = ack_count;
    req_valid = 4'b0001;
    @(negedge ref_clk);
    req_valid = 4'b0000;
    wait_wait_entry("t6_wait_entry");
    repeat (10) @(negedge ref_clk);
    resetn = 1'b0;
    #1;
    check_reset_values("t6");
    repeat (2) @(negedge ref_clk);
    resetn = 1'b1;
    repeat (150) @(negedge ref_clk);
    chk("t6_no_ack", 32'(ack_count), 32'(base));
    chk("queue_empty", 32'(exp_q.size()), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/clock_sched.md
CLOCK_SCHED -- requirements
Module: clock_sched

Interface
REQ-001 The module SHALL have parameter RST_CYCLES, default 8, meaning the number of ref_clk cycles osc_resetn is held low per programming attempt.
REQ-002 The module SHALL have parameter TIMEOUT, default 16'hFFFF, meaning the maximum number of ref_clk cycles to wait for lock per attempt.
REQ-003 The module SHALL have parameter REF_WINDOW, default 16'd1000, meaning the constant value driven on osc_ref_counter.
REQ-004 The module SHALL have port ref_clk  input  1  sole clock; all logic SHALL be on its rising edge.
REQ-005 The module SHALL have port resetn  input  1  asynchronous active-low reset.
REQ-006 The module SHALL have port req_valid  input  4  per-requester frequency request; bit i belongs to requester i.
REQ-007 The module SHALL have port req_init  input  36  requested tap init; requester i uses [9i+8:9i].
REQ-008 The module SHALL have port req_counter  input  64  requested target count; requester i uses [16i+15:16i].
REQ-009 The module SHALL have port req_ack  output  4  one-cycle completion pulse to the owning requester.
REQ-010 The module SHALL have port req_ok  output  1  result qualifier, valid only while any req_ack bit is high: 1=locked, 0=failed.
REQ-011 The module SHALL have port owner  output  2  index of the last granted requester.
REQ-012 The module SHALL have port busy  output  1  high in states RST and WAIT.
REQ-013 The module SHALL have port lock_lost  output  1  sticky flag indicating lock dropped during HOLD.
REQ-014 The module SHALL have ports osc_resetn (output, 1), osc_init (output, 9), osc_counter (output, 16), and osc_ref_counter (output, 16) driving the oscillator controller's resetn, init, counter, and ref_counter.
REQ-015 The module SHALL have port osc_status  input  3  controller status: [0]=locked, [1]=calibrating, [2]=calibration failed.

Function
REQ-016 osc_status SHALL pass through a 2-flop synchronizer (reset 0); all decisions SHALL use the synchronized value st.
REQ-017 The FSM SHALL have states IDLE, RST, WAIT, HOLD; in IDLE osc_resetn=0.
REQ-018 In IDLE or HOLD with any req_valid high, the module SHALL grant round-robin, searching from (owner+1) mod 4 upward; the grant SHALL latch owner, osc_init, and osc_counter from the winner in the same edge and enter RST.
REQ-019 RST SHALL drive osc_resetn=0 for exactly RST_CYCLES cycles, then enter WAIT with osc_resetn=1 and the timeout counter cleared.
REQ-020 In WAIT, st[0]=1 SHALL pulse req_ack[owner] with req_ok=1 and enter HOLD.
REQ-021 In WAIT, st[2]=1 or a timeout count reaching TIMEOUT SHALL pulse req_ack[owner] with req_ok=0 and enter IDLE.
REQ-022 If st[0] and st[2] are both high in WAIT, lock SHALL take priority.
REQ-023 HOLD SHALL keep osc_resetn=1 and osc_init/osc_counter stable.
REQ-024 In HOLD, st[0] falling to 0 SHALL set lock_lost; lock_lost SHALL clear only at the next grant.
REQ-025 req_valid SHALL be sampled only in IDLE and HOLD; requests arriving in RST or WAIT SHALL wait, and a bit dropped before grant SHALL be forgotten.
REQ-026 A requester still asserting req_valid the cycle after its ack SHALL be treated as a new request.
REQ-027 The timeout counter SHALL be 16 bits and SHALL saturate, never wrap.
REQ-028 osc_ref_counter SHALL equal REF_WINDOW at all times.

Reset
REQ-029 On resetn low, the module SHALL asynchronously enter IDLE.
REQ-030 Reset values SHALL be: osc_resetn=0, osc_init=0, osc_counter=0, owner=3 (so requester 0 wins first), req_ack=0, req_ok=0, busy=0, lock_lost=0, synchronizer=0.
REQ-031 A reset mid-operation SHALL abort without an ack.

Configuration
REQ-032 With CLOCK_SCHED_RETRY_EN defined, a failed WAIT SHALL re-enter RST up to 2 extra times (3 attempts total, retry count cleared per grant) before acking req_ok=0; without the macro, the first failure SHALL ack immediately.

Verification
REQ-033 Bench SHALL cover: reset, req_valid=4'b0001 with init=9'd100 and counter=16'd5000, st[0] raised 20 cycles after RST -> osc_resetn low 8 cycles, req_ack=4'b0001 with req_ok=1, state HOLD.
REQ-034 Bench SHALL cover: req_valid=4'b1111 held, each acked with success -> grant order 0,1,2,3,0.
REQ-035 Bench SHALL cover: st[2] pulsed in WAIT, macro off -> one ack with req_ok=0, osc_resetn=0; macro on -> 3 RST phases and then a fail ack.
REQ-036 Bench SHALL cover: TIMEOUT=100, status held at 0 -> fail ack exactly 100 cycles after WAIT entry (macro off).
REQ-037 Bench SHALL cover: in HOLD, st[0] dropped -> lock_lost=1 held; a new grant to requester 2 -> lock_lost=0.
REQ-038 Bench SHALL cover: resetn asserted mid-WAIT -> all outputs at reset values immediately and no ack.
